// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync, blank and frame
// pulses, all aligned with DrawX/DrawY. Defining VGA_FRAME_COUNT_EN enables
// the animation frame counter (frame_count / anim_tick). Without it, both
// outputs are tied to zero.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int ANIM_DIV = 8
) (
   input  logic       vga_clk,
   input  logic       Reset,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       frame_start,
   output logic       frame_end,
   output logic [5:0] frame_count,
   output logic       anim_tick
);

   // Boundaries, pre-sized to the counter width.
   localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
   localparam logic [9:0] H_VIS_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       blank_q, blank_d;
   logic       frame_start_q, frame_start_d;
   logic       frame_end_q, frame_end_d;

   // Next counter position, plus outputs decoded from that next position so
   // that once registered they line up with the registered counters.
   always_comb begin
      hc_d = hc_q + 10'd1;
      vc_d = vc_q;
      if (hc_q == H_LAST) begin
         hc_d = '0;
         if (vc_q == V_LAST) begin
            vc_d = '0;
         end else begin
            vc_d = vc_q + 10'd1;
         end
      end
      hs_d          = !((hc_d >= HS_START) && (hc_d < HS_END));
      vs_d          = !((vc_d >= VS_START) && (vc_d < VS_END));
      blank_d       = (hc_d < H_VIS) && (vc_d < V_VIS);
      frame_start_d = (hc_d == '0) && (vc_d == '0);
      frame_end_d   = (hc_d == H_VIS_LAST) && (vc_d == V_VIS_LAST);
   end

   // Counter and timing-output registers; reset abandons any partial frame.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         hc_q          <= '0;
         vc_q          <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_q       <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
      end
   end

   assign DrawX       = hc_q;
   assign DrawY       = vc_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign blank       = blank_q;
   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;

`ifdef VGA_FRAME_COUNT_EN
   localparam logic [5:0] DIV_LAST = 6'(ANIM_DIV - 1);

   logic [5:0] sub_q, sub_d;
   logic [5:0] fc_q, fc_d;
   logic       tick_q, tick_d;

   // Count frame_end events; every ANIM_DIV-th one advances frame_count and
   // raises anim_tick in the same cycle as that frame_end.
   always_comb begin
      sub_d  = sub_q;
      fc_d   = fc_q;
      tick_d = 1'b0;
      if (frame_end_d) begin
         if (sub_q == DIV_LAST) begin
            sub_d  = '0;
            fc_d   = fc_q + 6'd1;
            tick_d = 1'b1;
         end else begin
            sub_d = sub_q + 6'd1;
         end
      end
   end

   // Animation counter registers.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         sub_q  <= '0;
         fc_q   <= '0;
         tick_q <= 1'b0;
      end else begin
         sub_q  <= sub_d;
         fc_q   <= fc_d;
         tick_q <= tick_d;
      end
   end

   assign frame_count = fc_q;
   assign anim_tick   = tick_q;
`else
   assign frame_count = '0;
   assign anim_tick   = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a reduced-geometry instance (fast frames) and
// a default-geometry instance, both checked every cycle against a position
// model derived from the number of edges since reset was released.
module tb_vga_timing_gen;

   // Reduced geometry for the small instance.
   localparam int HA = 16, HFP = 4, HSW = 6, HBP = 4;
   localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
   localparam int HT = HA + HFP + HSW + HBP;   // 30
   localparam int VT = VA + VFP + VSW + VBP;   // 15
   localparam int FT = HT * VT;                // 450
   localparam int DIV = 8;

   logic       vga_clk = 1'b0;
   logic       Reset   = 1'b1;

   logic [9:0] s_x, s_y, d_x, d_y;
   logic       s_hs, s_vs, s_bl, s_fs, s_fe, s_tk;
   logic       d_hs, d_vs, d_bl, d_fs, d_fe, d_tk;
   logic [5:0] s_fc, d_fc;

   int tests_run    = 0;
   int tests_failed = 0;

   // Model state
   int k     = 0;   // edges since the last reset edge
   int sub   = 0;
   int fcnt  = 0;
   int cyc   = 0;
   int last_fs = -1;
   int n_fe = 0, n_fs = 0, n_tk = 0;
   int hs_low0 = 0, hs_first0 = -1, bl_low0 = 0;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .ANIM_DIV(DIV)
   ) u_small (
      .vga_clk(vga_clk), .Reset(Reset), .DrawX(s_x), .DrawY(s_y),
      .hs(s_hs), .vs(s_vs), .blank(s_bl), .frame_start(s_fs),
      .frame_end(s_fe), .frame_count(s_fc), .anim_tick(s_tk)
   );

   vga_timing_gen u_dflt (
      .vga_clk(vga_clk), .Reset(Reset), .DrawX(d_x), .DrawY(d_y),
      .hs(d_hs), .vs(d_vs), .blank(d_bl), .frame_start(d_fs),
      .frame_end(d_fe), .frame_count(d_fc), .anim_tick(d_tk)
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   // One clock edge: advance the model, then compare both instances.
   task automatic step();
      bit rst;
      int pos, ex, ey, ex2, ey2, efc;
      bit ehs, evs, ebl, efs, efe, etk, ehs2, evs2, ebl2;
      rst = Reset;
      @(posedge vga_clk);
      cyc++;
      if (rst) begin
         k = 0; sub = 0; fcnt = 0;
      end else begin
         k++;
      end
      pos = k % FT;
      ex  = pos % HT;
      ey  = pos / HT;
      ex2 = k % 800;
      ey2 = (k / 800) % 525;
      ehs  = rst ? 1'b1 : !(ex >= HA + HFP && ex < HA + HFP + HSW);
      evs  = rst ? 1'b1 : !(ey >= VA + VFP && ey < VA + VFP + VSW);
      ebl  = rst ? 1'b0 : (ex < HA && ey < VA);
      efs  = !rst && ex == 0 && ey == 0;
      efe  = !rst && ex == HA - 1 && ey == VA - 1;
      ehs2 = rst ? 1'b1 : !(ex2 >= 656 && ex2 < 752);
      evs2 = rst ? 1'b1 : !(ey2 >= 490 && ey2 < 492);
      ebl2 = rst ? 1'b0 : (ex2 < 640 && ey2 < 480);
      etk = 1'b0;
      if (efe) begin
         sub++;
         if (sub == DIV) begin
            sub = 0;
            fcnt = (fcnt + 1) % 64;
            etk = 1'b1;
         end
      end
`ifdef VGA_FRAME_COUNT_EN
      efc = fcnt;
`else
      efc = 0;
      etk = 1'b0;
`endif
      #1;
      check_eq("s_x", int'(s_x), ex);
      check_eq("s_y", int'(s_y), ey);
      check_eq("s_hs", int'(s_hs), int'(ehs));
      check_eq("s_vs", int'(s_vs), int'(evs));
      check_eq("s_blank", int'(s_bl), int'(ebl));
      check_eq("s_fstart", int'(s_fs), int'(efs));
      check_eq("s_fend", int'(s_fe), int'(efe));
      check_eq("s_fcount", int'(s_fc), efc);
      check_eq("s_tick", int'(s_tk), int'(etk));
      check_eq("d_x", int'(d_x), ex2);
      check_eq("d_y", int'(d_y), ey2);
      check_eq("d_hs", int'(d_hs), int'(ehs2));
      check_eq("d_vs", int'(d_vs), int'(evs2));
      check_eq("d_blank", int'(d_bl), int'(ebl2));
      // Pulse statistics and line-0 sync statistics of the default instance
      if (rst) last_fs = -1;
      if (s_fs) begin
         if (last_fs >= 0) check_eq("fs_period", cyc - last_fs, FT);
         last_fs = cyc;
         n_fs++;
      end
      if (s_fe) n_fe++;
      if (s_tk) n_tk++;
      if (!rst && d_y == 10'd0) begin
         if (!d_hs) begin
            if (hs_first0 < 0) hs_first0 = int'(d_x);
            hs_low0++;
         end
         if (!d_bl) bl_low0++;
      end
   endtask

   initial begin
      int hold, guard;
      bit found;
      // Reset held for three edges
      Reset = 1'b1;
      repeat (3) step();
      check_eq("rst_hs", int'(s_hs), 1);
      check_eq("rst_vs", int'(s_vs), 1);
      // Release: exactly 17 small frames without reset
      Reset = 1'b0;
      n_fe = 0; n_fs = 0; n_tk = 0;
      step();
      check_eq("first_x", int'(s_x), 1);
      check_eq("first_blank", int'(s_bl), 1);
      repeat (17 * FT - 1) step();
      check_eq("n_fend_17", n_fe, 17);
      check_eq("n_fstart_17", n_fs, 17);
`ifdef VGA_FRAME_COUNT_EN
      check_eq("fcount_17", int'(s_fc), 2);
      check_eq("n_tick_17", n_tk, 2);
`else
      check_eq("fcount_17", int'(s_fc), 0);
      check_eq("n_tick_17", n_tk, 0);
`endif
      check_eq("d_hs_low_len", hs_low0, 96);
      check_eq("d_hs_low_start", hs_first0, 656);
      check_eq("d_blank_low_len", bl_low0, 160);
      // Random reset bursts
      hold = 0;
      repeat (6000) begin
         if (hold > 0) begin
            hold--;
            if (hold == 0) Reset = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            Reset = 1'b1;
            hold = $urandom_range(1, 3);
         end
         step();
      end
      Reset = 1'b0;
      // Reset during simultaneous hsync and vsync
      found = 1'b0;
      guard = 0;
      while (!found && guard < 2 * FT) begin
         step();
         guard++;
         if (!s_hs && !s_vs && s_x == 10'(HA + HFP + 2)) found = 1'b1;
      end
      check_eq("find_sync", int'(found), 1);
      n_fe = 0;
      Reset = 1'b1;
      step();
      check_eq("midsync_hs", int'(s_hs), 1);
      check_eq("midsync_vs", int'(s_vs), 1);
      check_eq("midsync_x", int'(s_x), 0);
      check_eq("midsync_y", int'(s_y), 0);
      Reset = 1'b0;
      repeat (5) step();
      check_eq("midsync_no_fend", n_fe, 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter ANIM_DIV, default 8, frames per anim_tick (range 1..63).
REQ-010 SHALL have port vga_clk  input  1  pixel clock (25 MHz); the only clock.
REQ-011 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-012 SHALL have port DrawX  output  10  current horizontal count.
REQ-013 SHALL have port DrawY  output  10  current vertical count.
REQ-014 SHALL have port hs  output  1  horizontal sync, active low.
REQ-015 SHALL have port vs  output  1  vertical sync, active low.
REQ-016 SHALL have port blank  output  1  high = visible pixel, sprite/palette stages drive colour only when high.
REQ-017 SHALL have port frame_start  output  1  one-cycle pulse at pixel (0,0).
REQ-018 SHALL have port frame_end  output  1  one-cycle pulse at last visible pixel.
REQ-019 SHALL have port frame_count  output  6  animation frame index.
REQ-020 SHALL have port anim_tick  output  1  one-cycle pulse every ANIM_DIV frames.

Function
REQ-021 SHALL keep horizontal counter hc in 0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default), incrementing every vga_clk edge.
REQ-022 SHALL wrap hc to 0 after H_TOTAL-1 and on that same edge increment vc; vc wraps to 0 after V_TOTAL-1 (525 default).
REQ-023 SHALL drive DrawX = hc and DrawY = vc, both registered, no additional latency.
REQ-024 SHALL register hs, vs, blank, frame_start, frame_end from next-state counter values so every output is aligned with the DrawX/DrawY of the same cycle.
REQ-025 SHALL drive hs low iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751 default).
REQ-026 SHALL drive vs low iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491 default), across the entire line including blanking.
REQ-027 SHALL drive blank high iff hc < H_ACTIVE and vc < V_ACTIVE.
REQ-028 SHALL pulse frame_start high for exactly the cycle where hc=0, vc=0.
REQ-029 SHALL pulse frame_end high for exactly the cycle where hc=H_ACTIVE-1, vc=V_ACTIVE-1.
REQ-030 SHALL assert at most one of frame_start/frame_end in any cycle.

Reset
REQ-031 SHALL, on any edge with Reset high, set hc=0, vc=0, DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0, frame_end=0, frame_count=0, anim_tick=0.
REQ-032 SHALL, on the first edge with Reset low, advance to hc=1, vc=0 with blank=1; pixel (0,0) of the first frame after reset is not displayed and frame_start is not issued until the next wrap.
REQ-033 SHALL honour Reset asserted mid-line or mid-sync immediately at the next edge, abandoning the partial frame without a frame_end pulse.

Configuration
REQ-034 SHALL, with macro VGA_FRAME_COUNT_EN defined, increment a frame sub-counter on each frame_end, and on the ANIM_DIV-th frame_end clear it, increment frame_count (modulo 64) and pulse anim_tick for that same cycle.
REQ-035 SHALL, without VGA_FRAME_COUNT_EN, hold frame_count=0 and anim_tick=0 permanently while keeping all other behaviour identical.

Verification
REQ-036 SHALL verify: Reset high 3 cycles then low -> DrawX=1, DrawY=0, blank=1 after first edge; hs=vs=1 throughout reset.
REQ-037 SHALL verify: run one line -> hs low for exactly 96 cycles starting at DrawX=656; blank low from DrawX=640 to 799; DrawX wraps 799->0 with DrawY +1.
REQ-038 SHALL verify: run one frame -> vs low exactly on DrawY=490,491 (1600 cycles); DrawY wraps 524->0; frame_start once at (0,0), frame_end once at (639,479), period 420000 cycles.
REQ-039 SHALL verify: with VGA_FRAME_COUNT_EN and ANIM_DIV=8, run 17 frames -> anim_tick pulses on the 8th and 16th frame_end, frame_count=2; without the macro frame_count=0, anim_tick never high.
REQ-040 SHALL verify: assert Reset at DrawX=700, DrawY=490 (hs and vs low) -> next edge hs=1, vs=1, DrawX=0, DrawY=0, no frame_end emitted.
